// File: rtl/core_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_seq_pkg
// Description : Shared definitions for the core instruction sequencer:
//               instruction-word bit positions, the idle instruction word
//               and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package core_seq_pkg;

    // Instruction word bit positions
    localparam int c_bit_load     = 0;
    localparam int c_bit_execute  = 1;
    localparam int c_bit_l0_wr    = 2;
    localparam int c_bit_l0_rd    = 3;
    localparam int c_bit_ofifo_rd = 6;
    localparam int c_xa_lo        = 7;
    localparam int c_xa_hi        = 17;
    localparam int c_bit_wen_xmem = 18;
    localparam int c_bit_cen_xmem = 19;
    localparam int c_pa_lo        = 20;
    localparam int c_pa_hi        = 30;
    localparam int c_bit_wen_pmem = 31;
    localparam int c_bit_cen_pmem = 32;
    localparam int c_bit_acc      = 33;
    localparam int c_bit_passthru = 34;
    localparam int c_bit_ren_pmem = 35;
    localparam int c_bit_relu     = 45;

    // Idle word: both memories disabled, xmem write-enable deasserted (1).
    localparam logic [63:0] c_idle_word = 64'h0000_0001_000C_0000;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        WREAD   = 4'd1,
        WLOAD   = 4'd2,
        WSETTLE = 4'd3,
        AREAD   = 4'd4,
        EXEC    = 4'd5,
        DRAIN   = 4'd6,
        ACC     = 4'd7,
        RELU    = 4'd8,
        DONE    = 4'd9
    } seq_state_t;

endpackage : core_seq_pkg
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder
// Description : Combinational packer of the named core control fields into
//               the 64-bit core instruction word. Unused bits are driven 0.
// Ports       : *_i   control fields (load, execute, L0, OFIFO, xmem, pmem,
//                     acc, passthrough, relu)
//               inst_o packed instruction word
// Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder
    import core_seq_pkg::*;
(
    input  logic        load_i,
    input  logic        execute_i,
    input  logic        l0_wr_i,
    input  logic        l0_rd_i,
    input  logic        ofifo_rd_i,
    input  logic [10:0] a_xmem_i,
    input  logic        wen_xmem_i,
    input  logic        cen_xmem_i,
    input  logic [10:0] a_pmem_i,
    input  logic        wen_pmem_i,
    input  logic        cen_pmem_i,
    input  logic        acc_i,
    input  logic        passthrough_i,
    input  logic        ren_pmem_i,
    input  logic        relu_i,
    output logic [63:0] inst_o
);

    always_comb begin
        inst_o                    = '0;
        inst_o[c_bit_load]        = load_i;
        inst_o[c_bit_execute]     = execute_i;
        inst_o[c_bit_l0_wr]       = l0_wr_i;
        inst_o[c_bit_l0_rd]       = l0_rd_i;
        inst_o[c_bit_ofifo_rd]    = ofifo_rd_i;
        inst_o[c_xa_hi:c_xa_lo]   = a_xmem_i;
        inst_o[c_bit_wen_xmem]    = wen_xmem_i;
        inst_o[c_bit_cen_xmem]    = cen_xmem_i;
        inst_o[c_pa_hi:c_pa_lo]   = a_pmem_i;
        inst_o[c_bit_wen_pmem]    = wen_pmem_i;
        inst_o[c_bit_cen_pmem]    = cen_pmem_i;
        inst_o[c_bit_acc]         = acc_i;
        inst_o[c_bit_passthru]    = passthrough_i;
        inst_o[c_bit_ren_pmem]    = ren_pmem_i;
        inst_o[c_bit_relu]        = relu_i;
    end

endmodule : inst_encoder
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer
// Description : Issues the 64-bit core instruction stream for one full
//               convolution pass (weight load, activation load, execute,
//               OFIFO drain, psum accumulate) per kernel position, started by
//               'start' and finished with a one-cycle 'done' pulse.
//               Optional feature macro: CORE_SEQ_RELU_EN (adds an in-place
//               ReLU sweep over pmem after the last kernel position).
// Ports       : clk, reset (sync, active-high), start, ofifo_valid,
//               inst[63:0], busy, done, kij[3:0] (all outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int          col     = 8,
    parameter int          row     = 8,
    parameter int          len_kij = 9,
    parameter int          len_nij = 36,
    parameter logic [10:0] A_BASE  = 11'd0,
    parameter logic [10:0] W_BASE  = 11'd64,
    parameter logic [10:0] P_BASE  = 11'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [63:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij
);

    // Step-counter terminal values (counter is 0-based per state)
    localparam logic [15:0] c_wread_last  = 16'(col);
    localparam logic [15:0] c_col_cnt     = 16'(col);
    localparam logic [15:0] c_wload_last  = 16'(col - 1);
    localparam logic [15:0] c_settle_last = 16'(row - 1);
    localparam logic [15:0] c_nij_cnt     = 16'(len_nij);
    localparam logic [15:0] c_aread_last  = 16'(len_nij);
    localparam logic [15:0] c_nij_last    = 16'(len_nij - 1);
    localparam logic [10:0] c_col_a       = 11'(col);
    localparam logic [3:0]  c_kij_last    = 4'(len_kij - 1);

    seq_state_t  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  kij_q, kij_d;
    logic        l0_wr_q;
    logic [63:0] inst_q;
    logic        busy_q, done_q;
    logic [3:0]  kij_out_q;

    // Control fields decoded from the current state
    logic        ctl_load, ctl_exec, ctl_l0_rd, ctl_ofifo_rd;
    logic        ctl_xrd, ctl_pwr, ctl_acc, ctl_ren, ctl_relu;
    logic [10:0] ctl_a_xmem, ctl_a_pmem;
    logic [63:0] enc_inst;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 16'd1;
        kij_d        = kij_q;
        ctl_load     = 1'b0;
        ctl_exec     = 1'b0;
        ctl_l0_rd    = 1'b0;
        ctl_ofifo_rd = 1'b0;
        ctl_xrd      = 1'b0;
        ctl_pwr      = 1'b0;
        ctl_acc      = 1'b0;
        ctl_ren      = 1'b0;
        ctl_relu     = 1'b0;
        ctl_a_xmem   = '0;
        ctl_a_pmem   = '0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // busy_q is still high in the cycle 'done' is visible, so a
                // start coinciding with done is dropped.
                if (start && !busy_q) begin
                    kij_d   = '0;
                    state_d = WREAD;
                end
            end
            WREAD: begin
                if (cnt_q < c_col_cnt) begin
                    ctl_xrd    = 1'b1;
                    ctl_a_xmem = W_BASE + 11'(kij_q) * c_col_a + cnt_q[10:0];
                end
                if (cnt_q == c_wread_last) begin
                    cnt_d   = '0;
                    state_d = WLOAD;
                end
            end
            WLOAD: begin
                ctl_l0_rd = 1'b1;
                ctl_load  = 1'b1;
                if (cnt_q == c_wload_last) begin
                    cnt_d   = '0;
                    state_d = WSETTLE;
                end
            end
            WSETTLE: begin
                if (cnt_q == c_settle_last) begin
                    cnt_d   = '0;
                    state_d = AREAD;
                end
            end
            AREAD: begin
                if (cnt_q < c_nij_cnt) begin
                    ctl_xrd    = 1'b1;
                    ctl_a_xmem = A_BASE + cnt_q[10:0];
                end
                if (cnt_q == c_aread_last) begin
                    cnt_d   = '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                ctl_l0_rd = 1'b1;
                ctl_exec  = 1'b1;
                if (cnt_q == c_nij_last) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                cnt_d = '0;
                if (ofifo_valid) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                ctl_ofifo_rd = 1'b1;
                ctl_pwr      = 1'b1;
                ctl_a_pmem   = P_BASE + cnt_q[10:0];
                // First kernel position overwrites; later ones accumulate.
                if (kij_q != 4'd0) begin
                    ctl_ren = 1'b1;
                    ctl_acc = 1'b1;
                end
                if (cnt_q == c_nij_last) begin
                    cnt_d = '0;
                    if (kij_q == c_kij_last) begin
`ifdef CORE_SEQ_RELU_EN
                        state_d = RELU;
`else
                        state_d = DONE;
`endif
                    end else begin
                        kij_d   = kij_q + 4'd1;
                        state_d = WREAD;
                    end
                end
            end
`ifdef CORE_SEQ_RELU_EN
            RELU: begin
                ctl_pwr    = 1'b1;
                ctl_ren    = 1'b1;
                ctl_relu   = 1'b1;
                ctl_a_pmem = P_BASE + cnt_q[10:0];
                if (cnt_q == c_nij_last) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    inst_encoder u_inst_encoder (
        .load_i        (ctl_load),
        .execute_i     (ctl_exec),
        .l0_wr_i       (l0_wr_q),
        .l0_rd_i       (ctl_l0_rd),
        .ofifo_rd_i    (ctl_ofifo_rd),
        .a_xmem_i      (ctl_a_xmem),
        .wen_xmem_i    (1'b1),
        .cen_xmem_i    (~ctl_xrd),
        .a_pmem_i      (ctl_a_pmem),
        .wen_pmem_i    (ctl_pwr),
        .cen_pmem_i    (~ctl_pwr),
        .acc_i         (ctl_acc),
        .passthrough_i (1'b0),
        .ren_pmem_i    (ctl_ren),
        .relu_i        (ctl_relu),
        .inst_o        (enc_inst)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            kij_q     <= '0;
            l0_wr_q   <= 1'b0;
            inst_q    <= c_idle_word;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            kij_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            kij_q     <= kij_d;
            // l0_wr trails the xmem read by one instruction word
            l0_wr_q   <= ctl_xrd;
            inst_q    <= enc_inst;
            busy_q    <= (state_q != IDLE);
            done_q    <= (state_q == DONE);
            kij_out_q <= kij_q;
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;
    assign kij  = kij_out_q;

endmodule : core_sequencer
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_sequencer
// Description : Directed self-checking bench for core_sequencer at default
//               parameters. Expected instruction words come from a per-cycle
//               timeline of one kernel position (135 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_sequencer;

    localparam logic [63:0] c_idle = 64'h0000_0001_000C_0000;
    localparam int          c_kij_len = 135;
`ifdef CORE_SEQ_RELU_EN
    localparam int          c_pass_len = 9 * 135 + 36;
`else
    localparam int          c_pass_len = 9 * 135;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [63:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij;

    int checks = 0;
    int errors = 0;

    core_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done),
        .kij         (kij)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Expected word at offset o (0..134) within kernel position k.
    // 0-8 WREAD, 9-16 WLOAD, 17-24 WSETTLE, 25-61 AREAD, 62-97 EXEC,
    // 98 DRAIN (ofifo_valid high), 99-134 ACC.
    function automatic logic [63:0] exp_inst(input int k, input int o);
        logic [63:0] w;
        w = c_idle;
        if (o < 8) begin
            w[19]   = 1'b0;
            w[17:7] = 11'(64 + 8 * k + o);
            w[2]    = (o > 0);
        end else if (o == 8) begin
            w[2] = 1'b1;
        end else if (o <= 16) begin
            w[0] = 1'b1;
            w[3] = 1'b1;
        end else if (o <= 24) begin
            w = c_idle;
        end else if (o <= 60) begin
            w[19]   = 1'b0;
            w[17:7] = 11'(o - 25);
            w[2]    = (o > 25);
        end else if (o == 61) begin
            w[2] = 1'b1;
        end else if (o <= 97) begin
            w[1] = 1'b1;
            w[3] = 1'b1;
        end else if (o == 98) begin
            w = c_idle;
        end else begin
            w[6]     = 1'b1;
            w[32]    = 1'b0;
            w[31]    = 1'b1;
            w[30:20] = 11'(o - 99);
            if (k != 0) begin
                w[35] = 1'b1;
                w[33] = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [63:0] exp_relu(input int i);
        logic [63:0] w;
        w        = c_idle;
        w[32]    = 1'b0;
        w[35]    = 1'b1;
        w[31]    = 1'b1;
        w[45]    = 1'b1;
        w[30:20] = 11'(i);
        return w;
    endfunction

    // Pulse start from IDLE and wait (bounded) for busy to rise.
    task automatic launch();
        logic seen;
        seen  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        chk("busy_rise", {63'd0, seen}, 64'd1);
    endtask

    // Full pass with ofifo_valid high; every cycle checked against the
    // timeline. A stray start mid-pass and one coincident with done must
    // leave the pass unchanged and not restart it.
    task automatic run_pass(input string name);
        int k;
        int o;
        launch();
        for (int t = 0; t < c_pass_len; t++) begin
            if (t < 9 * c_kij_len) begin
                k = t / c_kij_len;
                o = t % c_kij_len;
                chk($sformatf("%s_inst_t%0d", name, t), inst, exp_inst(k, o));
                chk($sformatf("%s_kij_t%0d", name, t), {60'd0, kij}, 64'(k));
            end else begin
                chk($sformatf("%s_relu_t%0d", name, t), inst, exp_relu(t - 9 * c_kij_len));
            end
            chk($sformatf("%s_busy_t%0d", name, t), {63'd0, busy}, 64'd1);
            chk($sformatf("%s_done_t%0d", name, t), {63'd0, done}, 64'd0);
            start = (t == 300);
            step();
        end
        start = 1'b0;
        chk($sformatf("%s_done_pulse", name), {63'd0, done}, 64'd1);
        chk($sformatf("%s_done_busy", name), {63'd0, busy}, 64'd1);
        chk($sformatf("%s_done_inst", name), inst, c_idle);
        start = 1'b1;
        step();
        start = 1'b0;
        chk($sformatf("%s_post_done", name), {63'd0, done}, 64'd0);
        chk($sformatf("%s_post_busy", name), {63'd0, busy}, 64'd0);
        chk($sformatf("%s_post_inst", name), inst, c_idle);
        step();
        chk($sformatf("%s_no_restart", name), {63'd0, busy}, 64'd0);
        step();
        chk($sformatf("%s_no_restart2", name), {63'd0, busy}, 64'd0);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        ofifo_valid = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset state and idle hold
        for (int n = 0; n < 10; n++) begin
            chk($sformatf("idle_inst_%0d", n), inst, c_idle);
            chk($sformatf("idle_busy_%0d", n), {63'd0, busy}, 64'd0);
            chk($sformatf("idle_done_%0d", n), {63'd0, done}, 64'd0);
            chk($sformatf("idle_kij_%0d", n), {60'd0, kij}, 64'd0);
            step();
        end

        // Full pass
        run_pass("pass1");

        // DRAIN held off by ofifo_valid low, then reset in kij=2 EXEC
        ofifo_valid = 1'b0;
        launch();
        for (int t = 0; t < 98; t++) begin
            chk($sformatf("dr_inst_t%0d", t), inst, exp_inst(0, t));
            step();
        end
        for (int n = 0; n < 50; n++) begin
            chk($sformatf("drain_inst_%0d", n), inst, c_idle);
            chk($sformatf("drain_busy_%0d", n), {63'd0, busy}, 64'd1);
            step();
        end
        ofifo_valid = 1'b1;
        step();
        chk("drain_exit_inst", inst, c_idle);
        step();
        chk("acc_first", inst, exp_inst(0, 99));
        for (int t = 100; t <= 2 * c_kij_len + 66; t++) begin
            step();
            chk($sformatf("dr2_inst_t%0d", t), inst, exp_inst(t / c_kij_len, t % c_kij_len));
            chk($sformatf("dr2_kij_t%0d", t), {60'd0, kij}, 64'(t / c_kij_len));
        end
        // Now showing the 5th EXEC word of kij=2
        chk("pre_reset_exec", inst, exp_inst(2, 66));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_inst", inst, c_idle);
        chk("rst_kij", {60'd0, kij}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        step();
        chk("rst_inst2", inst, c_idle);
        chk("rst_busy2", {63'd0, busy}, 64'd0);

        // Subsequent full pass after reset
        run_pass("pass2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_core_sequencer
`default_nettype wire
